// File: rtl/serial_add_sub_ctrl_pkg.sv
// ============================================================================
// serial_add_sub_ctrl_pkg : shared FSM state encoding and defaults
// Rev 1.0
// ============================================================================
`default_nettype none

package serial_add_sub_ctrl_pkg;

  // Encoding 2'd3 is unused; the controller falls back to ST_IDLE from it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/full_adder.sv
// ============================================================================
// full_adder : one-bit full adder built from two half adders
// Rev 1.0
// ============================================================================
`default_nettype none

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);

  logic s0, c0, c1;

  half_adder u_ha0 (
    .a_i (a_i),
    .b_i (b_i),
    .s_o (s0),
    .c_o (c0)
  );

  half_adder u_ha1 (
    .a_i (s0),
    .b_i (cin_i),
    .s_o (s_o),
    .c_o (c1)
  );

  assign cout_o = c0 | c1;

endmodule

`default_nettype wire

// File: rtl/half_adder.sv
// ============================================================================
// half_adder : one-bit sum/carry cell
// Rev 1.0
// ============================================================================
`default_nettype none

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

`default_nettype wire

// File: rtl/serial_add_sub_ctrl.sv
// ============================================================================
// serial_add_sub_ctrl : bit-serial add/subtract through a single full adder
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_add_sub_ctrl
  import serial_add_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] areg_q, areg_d;
  logic [WIDTH-1:0] breg_q, breg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             fa_s, fa_cout;

  full_adder u_fa (
    .a_i    (areg_q[0]),
    .b_i    (breg_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      areg_q   <= '0;
      breg_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      areg_q   <= areg_d;
      breg_q   <= breg_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    areg_d   = areg_q;
    breg_d   = breg_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start_i) begin
          // Subtraction is a + ~b + 1: invert b here, the +1 rides in on carry.
          state_d = ST_RUN;
          areg_d  = a_i;
          breg_d  = b_i ^ {WIDTH{sub_i}};
          carry_d = sub_i;
          cnt_d   = '0;
        end
      end

      ST_RUN: begin
        result_d = {fa_s, result_q[WIDTH-1:1]};
        areg_d   = {1'b0, areg_q[WIDTH-1:1]};
        breg_d   = {1'b0, breg_q[WIDTH-1:1]};
        carry_d  = fa_cout;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // carry_q is the carry into the MSB at this edge.
          cout_d  = fa_cout;
          ovf_d   = carry_q ^ fa_cout;
          state_d = ST_DONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy_o   = (state_q == ST_RUN);
  assign done_o   = (state_q == ST_DONE);
  assign result_o = result_q;
  assign cout_o   = cout_q;
  assign ovf_o    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub_ctrl.sv
// ============================================================================
// tb_serial_add_sub_ctrl : vector table, corner sequences and random ops
// against an arithmetic model, on WIDTH=4 and WIDTH=8 instances in parallel.
// ============================================================================
`default_nettype none

module tb_serial_add_sub_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a_bus, b_bus;

  logic       busy4, done4, cout4, ovf4;
  logic [3:0] res4;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] res8;

  int n_cmp = 0;
  int n_bad = 0;

  int         lat4, lat8, bz4, bz8;
  logic [3:0] cr4;
  logic [7:0] cr8;
  logic       cc4, co4, cc8, co8;

  always #5 clk = ~clk;

  serial_add_sub_ctrl #(.WIDTH(4), .CNT_W(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .sub_i    (sub),
    .a_i      (a_bus[3:0]),
    .b_i      (b_bus[3:0]),
    .busy_o   (busy4),
    .done_o   (done4),
    .result_o (res4),
    .cout_o   (cout4),
    .ovf_o    (ovf4)
  );

  serial_add_sub_ctrl #(.WIDTH(8), .CNT_W(4)) u_dut8 (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .sub_i    (sub),
    .a_i      (a_bus[7:0]),
    .b_i      (b_bus[7:0]),
    .busy_o   (busy8),
    .done_o   (done8),
    .result_o (res8),
    .cout_o   (cout8),
    .ovf_o    (ovf8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [3:0] r;
    logic       c;
    logic       o;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed/unsigned arithmetic reference for a w-bit add or subtract.
  task automatic model(input int w, input int a, input int b, input bit s,
                       output int r, output bit c, output bit o);
    int full, sa, sb, sr, half;
    full = 1 << w;
    half = 1 << (w - 1);
    sa = (a >= half) ? a - full : a;
    sb = (b >= half) ? b - full : b;
    if (s) begin
      r  = (a - b + full) % full;
      c  = (a >= b);
      sr = sa - sb;
    end else begin
      r  = (a + b) % full;
      c  = (a + b) >= full;
      sr = sa + sb;
    end
    o = (sr > half - 1) || (sr < -half);
  endtask

  // Launch one op on both instances; operands are scrambled right after accept.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    start = 1'b1; a_bus = a; b_bus = b; sub = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    a_bus = 16'($urandom); b_bus = 16'($urandom); sub = 1'($urandom);
    lat4 = 0; lat8 = 0; bz4 = 0; bz8 = 0;
    for (int n = 1; n <= 20 && (lat4 == 0 || lat8 == 0); n++) begin
      @(negedge clk);
      if (busy4) bz4++;
      if (busy8) bz8++;
      if (done4 && lat4 == 0) begin lat4 = n; cr4 = res4; cc4 = cout4; co4 = ovf4; end
      if (done8 && lat8 == 0) begin lat8 = n; cr8 = res8; cc8 = cout8; co8 = ovf8; end
    end
  endtask

  task automatic check_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [3:0] er4, input logic ec4,
                          input logic eo4);
    int r8; bit c8, o8;
    model(8, int'(a), int'(b), s, r8, c8, o8);
    check({tag, " w4 latency"}, lat4, 5);
    check({tag, " w4 busy"}, bz4, 4);
    check({tag, " w4 result"}, cr4, er4);
    check({tag, " w4 cout"}, cc4, ec4);
    check({tag, " w4 ovf"}, co4, eo4);
    check({tag, " w8 latency"}, lat8, 9);
    check({tag, " w8 busy"}, bz8, 8);
    check({tag, " w8 result"}, cr8, r8[7:0]);
    check({tag, " w8 cout"}, cc8, c8);
    check({tag, " w8 ovf"}, co8, o8);
  endtask

  initial begin
    vec_t vecs[7];
    int   r4, m, ndone;
    bit   c4, o4;
    logic [7:0] ra, rb;
    logic       rs;

    vecs[0] = '{4'b0111, 4'b0101, 1'b0, 4'b1100, 1'b0, 1'b1};
    vecs[1] = '{4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0};
    vecs[2] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1};
    vecs[3] = '{4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0};
    vecs[4] = '{4'b0010, 4'b0011, 1'b0, 4'b0101, 1'b0, 1'b0};
    vecs[5] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0};
    vecs[6] = '{4'b0111, 4'b1000, 1'b1, 4'b1111, 1'b0, 1'b1};

    rst = 1'b1; start = 1'b0; sub = 1'b0; a_bus = '0; b_bus = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset busy", busy4, 0);
    check("reset done", done4, 0);
    check("reset result", res4, 0);
    check("reset cout", cout4, 0);
    check("reset ovf", ovf4, 0);
    check("reset w8 result", res8, 0);

    for (int i = 0; i < 7; i++) begin
      run_op({12'd0, vecs[i].a}, {12'd0, vecs[i].b}, vecs[i].s);
      check_op($sformatf("vec%0d", i), {4'd0, vecs[i].a}, {4'd0, vecs[i].b}, vecs[i].s,
               vecs[i].r, vecs[i].c, vecs[i].o);
    end

    for (int i = 0; i < 200; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      model(4, int'(ra[3:0]), int'(rb[3:0]), rs, r4, c4, o4);
      run_op({8'd0, ra}, {8'd0, rb}, rs);
      check_op($sformatf("rand%0d", i), ra, rb, rs, r4[3:0], c4, o4);
    end

    // start held through RUN, then reissued with new operands in the DONE cycle.
    @(negedge clk);
    start = 1'b1; a_bus = 16'h000F; b_bus = 16'h0001; sub = 1'b0;
    @(posedge clk);
    lat4 = 0; bz4 = 0;
    for (int n = 1; n <= 20 && lat4 == 0; n++) begin
      @(negedge clk);
      if (busy4) bz4++;
      if (done4) begin
        lat4 = n;
        cr4 = res4; cc4 = cout4;
        a_bus = 16'h0002; b_bus = 16'h0003; sub = 1'b0;
      end else begin
        a_bus = 16'($urandom); b_bus = 16'($urandom);
      end
    end
    check("held-start latency", lat4, 5);
    check("held-start busy", bz4, 4);
    check("wrap result", cr4, 4'b0000);
    check("wrap cout", cc4, 1);
    @(posedge clk);
    #1 start = 1'b0;
    m = 0;
    for (int n = 1; n <= 20 && m == 0; n++) begin
      @(negedge clk);
      if (done4) begin m = n; cr4 = res4; end
    end
    check("back-to-back spacing", m, 5);
    check("back-to-back result", cr4, 4'b0101);

    // Reset sampled at the second RUN edge aborts without a done pulse.
    repeat (10) @(negedge clk);
    start = 1'b1; a_bus = 16'h0007; b_bus = 16'h0005; sub = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort busy", busy4, 0);
    check("abort done", done4, 0);
    check("abort result", res4, 0);
    check("abort cout", cout4, 0);
    check("abort ovf", ovf4, 0);
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4 || busy4) ndone++;
    end
    check("abort no done", ndone, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_sub_ctrl.md
Name: serial_add_sub_ctrl

Overview:
- Bit-serial add/subtract controller that time-multiplexes a single existing full_adder cell over WIDTH bits.
- Latches operands on a start request, feeds one bit pair per clock through the cell, and shifts the sum bits into a result register.
- Reports result, carry-out and signed overflow with a busy/done handshake.
- Area-reduced alternative to the ripple four-bit adder/subtractor, for the clock/counter logic on the Spartan-3 board.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..16.
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = a+b, 1 = a-b; latched with the operands.
- a  input  WIDTH  operand A (two's complement or unsigned).
- b  input  WIDTH  operand B.
- busy  output  1  high while bits are being processed (state RUN).
- done  output  1  one-cycle pulse; result, cout and ovf are valid.
- result  output  WIDTH  sum or difference.
- cout  output  1  carry out of MSB; in subtract mode 1 = no borrow (a >= b unsigned).
- ovf  output  1  signed overflow.

Behaviour:
- Reset (rst=1 at an edge, any state): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; bit counter=0; carry register=0; operand shift registers=0. Reset in the middle of RUN aborts the operation. No done pulse follows the abort.
- States:
  - IDLE: start=1 -> RUN. Accept edge E0 loads areg<=a, breg<=b^{WIDTH{sub}}, carry<=sub, cnt<=0, subreg<=sub.
  - RUN: busy=1. Each edge:
    - Full_adder inputs are a=areg[0], b=breg[0], cin=carry.
    - result <= {s, result[WIDTH-1:1]}, which shifts LSB-first into the MSB.
    - areg and breg shift right by 1.
    - carry <= cout of the cell.
    - cnt <= cnt+1.
    - At the edge where cnt==WIDTH-1, go to DONE.
  - DONE: done=1, busy=0, for exactly one cycle. start=1 in this cycle is accepted exactly as in IDLE (back-to-back, no idle bubble); otherwise -> IDLE.
- MSB handling: at the MSB edge, cout<=cell cout and ovf<=carry_in_to_MSB ^ cell_cout.
- Latency: the accept edge is E0. Bits are processed at edges E1..E(WIDTH), done is high between E(WIDTH) and E(WIDTH+1), and an operation occupies WIDTH+1 cycles.
- Output stability: result, cout and ovf are registered and hold their values from DONE until the next accept edge. During RUN, result holds the partial shift contents and is not valid.
- start during RUN: ignored, not queued.
- a, b and sub changing after the accept edge: no effect.
- Width rules:
  - All arithmetic is modulo 2**WIDTH.
  - Subtraction is a + ~b + 1, with the +1 supplied by the initial carry.
  - cout and ovf follow standard two's-complement adder semantics.
- Datapath: exactly one full_adder instance. No other adder logic is permitted (the counter increment excepted).

Decomposition:
- Shared include file serial_ctrl_defs.vh holds the state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2. Encoding 2'd3 is illegal; the FSM recovers to IDLE from it.
- Sub-module: the existing full_adder (built from two half_adders), instantiated once as the serial bit-slice.
- The controller contains the FSM, counter, operand shift registers and carry/result registers; no further sub-modules.

Test Plan:
- WIDTH=4. Add: a=0111, b=0101, sub=0, start pulse -> done 4 cycles after the accept edge; result=1100, cout=0, ovf=1. Check busy high for exactly 4 cycles.
- Subtract with borrow: a=0011, b=0101, sub=1 -> result=1110, cout=0, ovf=0. Subtract without borrow: a=1000, b=0001, sub=1 -> result=0111, cout=1, ovf=1.
- Wrap: a=1111, b=0001, sub=0 -> result=0000, cout=1, ovf=0. Then change a/b mid-RUN and confirm result is unaffected.
- start held high through RUN -> no restart during RUN. start=1 in the DONE cycle with new operands 0010+0011 -> second done exactly 5 cycles after the first; result=0101.
- Reset mid-operation: assert rst at the 2nd RUN edge -> next cycle busy=0, done=0, result=0, cout=0, ovf=0. No done appears within the following 10 cycles without a new start.
- Random: 200 random a/b/sub vectors compared against a behavioural a±b model for result, cout and ovf. Also repeat at WIDTH=8 with CNT_W=4.
